// File: rtl/rom_arbiter.sv
// Round-robin burst-read controller sharing one combinational 16x8 ROM between two requesters.
// Returns registered ROM data on a single read bus tagged with the owning requester.
module rom_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 4
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] start0,
   input  logic [ADDR_W-1:0] start1,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   output logic              grant0,
   output logic              grant1,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_owner,
   output logic              rd_last,
   output logic              busy
);

   typedef enum logic {IDLE, READ} state_t;

   state_t            state, state_nxt;
   logic              prio;
   logic              cur;
   logic [LEN_W:0]    remain;

   logic              gnt0_nxt, gnt1_nxt;
   logic              last_beat;
   logic [ADDR_W-1:0] start_sel;
   logic [LEN_W-1:0]  len_sel;
   logic [LEN_W:0]    len_full;

   assign busy = (state == READ);

   // Arbitration and next-state decode.
   // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
   always_comb begin
      state_nxt = state;
      gnt0_nxt  = 1'b0;
      gnt1_nxt  = 1'b0;
      last_beat = 1'b0;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || !prio)) begin
               gnt0_nxt  = 1'b1;
               state_nxt = READ;
            end else if (req1) begin
               gnt1_nxt  = 1'b1;
               state_nxt = READ;
            end
         end
         READ: begin
            if (remain == (LEN_W+1)'(1)) begin
               last_beat = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A length field of zero stands for the full 2^LEN_W beats.
   assign start_sel = gnt1_nxt ? start1 : start0;
   assign len_sel   = gnt1_nxt ? len1 : len0;
   assign len_full  = (len_sel == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_sel};

   // NOTE: all state and output registers use non-blocking assignments so every
   // right-hand side sees the pre-edge values, independent of statement order.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         prio     <= 1'b0;
         cur      <= 1'b0;
         remain   <= '0;
         grant0   <= 1'b0;
         grant1   <= 1'b0;
         rom_addr <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_owner <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant0   <= gnt0_nxt;
         grant1   <= gnt1_nxt;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;

         if (gnt0_nxt || gnt1_nxt) begin
            cur      <= gnt1_nxt;
            rom_addr <= start_sel;
            remain   <= len_full;
         end

         // The address wraps naturally at 2^ADDR_W.
         if (state == READ) begin
            rd_data  <= rom_data;
            rd_valid <= 1'b1;
            rd_owner <= cur;
            rom_addr <= rom_addr + 1'b1;
            remain   <= remain - 1'b1;
            if (last_beat) begin
               rd_last <= 1'b1;
               prio    <= ~cur;
            end
         end
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every beat the DUT presents.
module tb_rom_arbiter;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 4;

   logic              sysclk = 1'b0;
   logic              reset;
   logic              req0, req1;
   logic [ADDR_W-1:0] start0, start1;
   logic [LEN_W-1:0]  len0, len1;
   logic              grant0, grant1;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid, rd_owner, rd_last, busy;

   typedef struct packed {
      logic       owner;
      logic       last;
      logic [7:0] data;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_e;
   int    n_checks = 0;
   int    n_fail   = 0;

   always #10 sysclk = ~sysclk;

   // ROM model: data = {addr, ~addr}
   assign rom_data = {rom_addr, ~rom_addr};

   rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .req0     (req0),
      .req1     (req1),
      .start0   (start0),
      .start1   (start1),
      .len0     (len0),
      .len1     (len1),
      .grant0   (grant0),
      .grant1   (grant1),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_owner (rd_owner),
      .rd_last  (rd_last),
      .busy     (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rom_val(input logic [3:0] a);
      return {a, ~a};
   endfunction

   task automatic push_burst(input logic who, input logic [3:0] st, input logic [3:0] ln);
      int         n;
      logic [3:0] a;
      beat_t      b;
      n = (ln == 4'd0) ? 16 : int'(ln);
      for (int k = 0; k < n; k++) begin
         a       = st + 4'(k);
         b.owner = who;
         b.last  = (k == n - 1);
         b.data  = rom_val(a);
         exp_q.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   // Waits (bounded) for a grant pulse; who = -1 on timeout.
   task automatic wait_grant(output int who, output int cycles);
      who    = -1;
      cycles = 0;
      while (who < 0 && cycles < 40) begin
         tick();
         cycles++;
         if (grant0 || grant1) who = grant1 ? 1 : 0;
      end
      if (who < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL grant_timeout: no grant within %0d cycles", cycles);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, busy, 0);
      tick();
      tick();
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   // Single-requester burst; the request is dropped right after the grant and
   // start/len are scrambled to show they are not re-sampled.
   task automatic burst(input logic who, input logic [3:0] st, input logic [3:0] ln, input string tag);
      int g, cyc, nbusy, l;
      l = (ln == 4'd0) ? 16 : int'(ln);
      push_burst(who, st, ln);
      if (who) begin
         req1 = 1'b1; start1 = st; len1 = ln;
      end else begin
         req0 = 1'b1; start0 = st; len0 = ln;
      end
      wait_grant(g, cyc);
      check({tag, "_grant_who"}, g, who);
      check({tag, "_start_addr"}, rom_addr, st);
      check({tag, "_busy_on_grant"}, busy, 1);
      req0 = 1'b0; req1 = 1'b0;
      start0 = ~st; start1 = ~st; len0 = ln + 4'd3; len1 = ln + 4'd3;
      nbusy = 1;
      tick();
      check({tag, "_grant_pulse"}, grant0 | grant1, 0);
      while (busy && nbusy < 40) begin
         nbusy++;
         tick();
      end
      check({tag, "_busy_cycles"}, nbusy, l);
      tick();
      tick();
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant0"},   grant0,   0);
      check({tag, "_grant1"},   grant1,   0);
      check({tag, "_rom_addr"}, rom_addr, 0);
      check({tag, "_rd_data"},  rd_data,  0);
      check({tag, "_rd_valid"}, rd_valid, 0);
      check({tag, "_rd_owner"}, rd_owner, 0);
      check({tag, "_rd_last"},  rd_last,  0);
      check({tag, "_busy"},     busy,     0);
   endtask

   // Monitor: compare every presented beat against the scoreboard head.
   always @(negedge sysclk) begin
      if (!reset) begin
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: data 0x%0h owner %0d, no beat expected", rd_data, rd_owner);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_data",  rd_data,  mon_e.data);
               check("beat_owner", rd_owner, mon_e.owner);
               check("beat_last",  rd_last,  mon_e.last);
            end
         end else begin
            check("last_outside_beat", rd_last, 0);
         end
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g, cyc, n;
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      start0 = '0; start1 = '0; len0 = '0; len1 = '0;
      #5;
      check_all_zero("por");
      tick();
      reset = 1'b0;
      tick();

      // Single burst: 8'h3C then 8'h4B, last on second beat.
      exp_q.push_back(beat_t'({1'b0, 1'b0, 8'h3C}));
      exp_q.push_back(beat_t'({1'b0, 1'b1, 8'h4B}));
      req0 = 1'b1; start0 = 4'd3; len0 = 4'd2;
      wait_grant(g, cyc);
      check("single_grant_who", g, 0);
      check("single_start_addr", rom_addr, 3);
      check("single_busy", busy, 1);
      req0 = 1'b0;
      n = 1;
      tick();
      while (busy && n < 40) begin
         n++;
         tick();
      end
      check("single_busy_cycles", n, 2);
      tick();
      tick();
      check("single_drained", exp_q.size(), 0);

      // Wrap 14,15,0,1 then the 16-beat encoding from 5, ending at 4.
      burst(1'b1, 4'd14, 4'd4, "wrap");
      burst(1'b1, 4'd5,  4'd0, "len16");
      check("len16_end_addr", rom_addr, 5);

      // Requester drop mid-burst.
      burst(1'b0, 4'd9, 4'd5, "drop");

      // Reset brings prio back to 0 (it is 1 here).
      reset = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      tick();
      reset = 1'b0;
      tick();

      // Simultaneous requests: 0, then 1 after L+1, then 0 again.
      push_burst(1'b0, 4'd2, 4'd2);
      push_burst(1'b1, 4'd7, 4'd3);
      push_burst(1'b0, 4'd2, 4'd2);
      req0 = 1'b1; start0 = 4'd2; len0 = 4'd2;
      req1 = 1'b1; start1 = 4'd7; len1 = 4'd3;
      wait_grant(g, cyc);
      check("sim_first_who", g, 0);
      wait_grant(g, cyc);
      check("sim_second_who", g, 1);
      check("sim_second_gap", cyc, 3);
      wait_grant(g, cyc);
      check("sim_third_who", g, 0);
      check("sim_third_gap", cyc, 4);
      req0 = 1'b0; req1 = 1'b0;
      wait_idle("sim");

      // Request during burst: start1 taken in the grant cycle.
      push_burst(1'b0, 4'd0, 4'd4);
      req0 = 1'b1; start0 = 4'd0; len0 = 4'd4;
      wait_grant(g, cyc);
      check("during_first_who", g, 0);
      req0 = 1'b0;
      req1 = 1'b1; start1 = 4'd9; len1 = 4'd2;
      n = 0;
      while (busy && n < 40) begin
         check("during_no_grant1", grant1, 0);
         tick();
         n++;
      end
      start1 = 4'd11;
      push_burst(1'b1, 4'd11, 4'd2);
      wait_grant(g, cyc);
      check("during_second_who", g, 1);
      check("during_second_wait", cyc, 1);
      check("during_start_addr", rom_addr, 11);
      start1 = 4'd0; len1 = 4'd7; req1 = 1'b0;
      wait_idle("during");

      // Reset on beat 2 of 8, with req1 pending.
      push_burst(1'b0, 4'd4, 4'd8);
      req0 = 1'b1; start0 = 4'd4; len0 = 4'd8;
      req1 = 1'b1; start1 = 4'd1; len1 = 4'd1;
      wait_grant(g, cyc);
      check("rstmid_first_who", g, 0);
      req0 = 1'b0;
      tick();
      tick();
      tick();
      check("rstmid_beat2_valid", rd_valid, 1);
      reset = 1'b1;
      #1;
      check_all_zero("rstmid");
      tick();
      exp_q.delete();
      tick();
      reset = 1'b0;
      push_burst(1'b1, 4'd1, 4'd1);
      wait_grant(g, cyc);
      check("rstmid_after_who", g, 1);
      check("rstmid_after_addr", rom_addr, 1);
      req1 = 1'b0;
      wait_idle("rstmid");

      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Burst-read controller that shares the single 16x8 combinational ROM (`rom1`) between two requesters. Each requester asks for a burst of sequential ROM bytes from a start address. The block grants requesters round-robin, drives the ROM address, and returns registered ROM data on one shared read bus tagged with the owning requester. It sits between `rom1` and its two client blocks, all clocked by `sysclk`.

## Interface
- `ADDR_W`, default 4: ROM address width (16 locations).
- `DATA_W`, default 8: ROM data width.
- `LEN_W`, default 4: burst length field width.

- `sysclk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  level request; held high until the matching grant.
- `start0`, `start1`  in  ADDR_W  burst start address; sampled only in the grant cycle.
- `len0`, `len1`  in  LEN_W  beat count; 0 encodes 16 beats.
- `grant0`, `grant1`  out  1  one-cycle grant pulse.
- `rom_addr`  out  ADDR_W  address to `rom1`, registered.
- `rom_data`  in  DATA_W  combinational data from `rom1`.
- `rd_data`  out  DATA_W  registered read data.
- `rd_valid`  out  1  `rd_data` holds a valid beat.
- `rd_owner`  out  1  owner of the current beat (0 = requester 0, 1 = requester 1).
- `rd_last`  out  1  marks the final beat of a burst.
- `busy`  out  1  a burst is in progress (state READ).

## Operation
- States: IDLE and READ.
- Registers:
  - `prio`: requester favoured on a tie; 0 after reset.
  - `cur`: current owner.
  - `addr`: current address.
  - `remain`: beats left to issue, LEN_W+1 bits.
- IDLE:
  - If no `req` is high, stay in IDLE.
  - If one `req` is high, grant that requester.
  - If both are high, grant requester `prio`.
  - On grant: pulse `grantN`, set `cur`=N, load `rom_addr`=`startN`, set `remain` = (`lenN`==0 ? 16 : `lenN`), go to READ.
- READ, every cycle:
  - `rd_data` <= `rom_data`, `rd_valid` <= 1, `rd_owner` <= `cur`.
  - `rom_addr` <= `rom_addr`+1, wrapping 15 -> 0 (mod 2^ADDR_W). No error on wrap.
  - `remain` <= `remain`-1.
  - When `remain`==1, the beat issued is the last one: `rd_last` <= 1, state -> IDLE, `prio` <= ~`cur`.
- Outside a valid beat, `rd_valid` and `rd_last` are 0. `rd_data` holds its last value.
- In IDLE, `rom_addr` holds its last value.
- A requester dropping `req` mid-burst does not abort the burst. `req` is ignored in READ.
- `start`/`len` changes after the grant cycle have no effect.
- The block supports no more than two requesters. Bursts are never preempted.

## Timing
- Reset values:
  - Asynchronous, immediate: `grant0`/`grant1`=0, `rom_addr`=0, `rd_data`=0, `rd_valid`=0, `rd_owner`=0, `rd_last`=0, `busy`=0.
  - State IDLE, `prio`=0.
- Reset mid-burst aborts at once; the remaining beats are lost.
- Let E0 be the edge that ends the IDLE cycle in which `req` is high:
  - After E0: `grantN`=1 for exactly one cycle, `busy`=1, `rom_addr`=start.
  - Beat k (k = 0..L-1) has `rd_valid`=1 in the cycle after edge E(k+1).
  - First data appears 2 cycles after `req` is sampled.
  - `busy` is high for L cycles.
  - The cycle holding the last beat (`rd_last`=1) is an IDLE cycle, and arbitration happens in it.
  - The next grant lands at E(L+1): one cycle with `rd_valid`=0 separates back-to-back bursts.
- A request arriving while `busy` waits; it is evaluated in the first IDLE cycle.
- `rom_data` must settle within one `sysclk` period of a `rom_addr` change. `rom1` is combinational, so this holds.

## Test plan
- **Single burst.** Bench ROM model returns data = {addr, ~addr}. Stimulus: `req0`, `start0`=3, `len0`=2. Required: `grant0` pulse; beats 8'h3C then 8'h4B, `rd_owner`=0; `rd_last` on the second beat; `busy` for 2 cycles.
- **Wrap and 16-beat encoding.** Stimulus: `req1`, `start1`=14, `len1`=4. Required: addresses 14, 15, 0, 1. Then `len1`=0 from `start1`=5: exactly 16 beats, ending at address 4.
- **Simultaneous requests.** `req0` and `req1` high together after reset. Required: requester 0 is granted first. Requester 1 is granted at E(L+1) with one gap cycle. If both are still requesting, the third grant goes to requester 0.
- **Request during burst.** `req1` rises while `req0`'s 4-beat burst runs. Required: no `grant1` until `busy` falls. `start1` is taken from the grant cycle, not from when `req1` rose.
- **Reset mid-burst.** Assert `reset` on beat 2 of 8. Required: all outputs 0 immediately. After release: state IDLE, `prio`=0, a pending `req1` is granted with correct data.
- **Requester drop.** `req0` is deasserted after its grant. Required: the full burst still completes with correct `rd_last`.
